alu_result_buf: RTL

ALU_RESULT_BUF -- requirements
Module: alu_result_buf

---
 rtl/alu_defs.sv | 23 ++
 rtl/result_entry.sv | 26 ++
 rtl/alu_result_buf.sv | 123 ++++++++++++
 3 files changed

// File: rtl/alu_defs.sv
// Shared ALU constants: datapath and register-index widths, the default
// status register used for overflowing results, and the result-buffer entry
// layout.
package alu_defs;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned ENTRY_W = DATA_W + REG_W + 1;

  localparam logic [REG_W-1:0] RSTATUS_REG_DEF = 5'd30;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [REG_W-1:0]  rd;
    logic              ovf;
  } rb_entry_t;

  // 8-bit increment that sticks at all-ones.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/result_entry.sv
// One result-buffer slot: a {result, rd, ovf} register with write enable.
// Ports:
//   clock   - rising-edge clock
//   reset_n - asynchronous active-low clear
//   we      - load d on the next rising edge
//   d       - entry to store
//   q       - stored entry
module result_entry
  import alu_defs::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic               we,
  input  logic [ENTRY_W-1:0] d,
  output logic [ENTRY_W-1:0] q
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/alu_result_buf.sv
// Two-entry in-order result buffer between the execute-stage ALU/shifter and
// the memory stage. Results that overflowed are redirected to the status
// register and counted in a saturating overflow counter.
// Ports:
//   clock, reset_n                     - clock, asynchronous active-low reset
//   in_valid/in_ready                  - upstream handshake
//   in_result, in_rd, in_ovf           - incoming result, dest reg, overflow
//   flush                              - drop buffered and incoming results
//   out_valid/out_ready                - downstream handshake
//   out_result, out_rd, out_ovf        - head entry fields
//   ovf_count                          - saturating count of accepted overflows
module alu_result_buf
  import alu_defs::*;
#(
  parameter int unsigned      DEPTH       = 2,
  parameter logic [REG_W-1:0] RSTATUS_REG = RSTATUS_REG_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic [REG_W-1:0]  in_rd,
  input  logic              in_ovf,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [REG_W-1:0]  out_rd,
  output logic              out_ovf,
  output logic [7:0]        ovf_count
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  logic [1:0] count_q, count_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [7:0] ovf_count_q, ovf_count_d;

  logic       push, pop;
  rb_entry_t  wdata;
  rb_entry_t  head;
  rb_entry_t  slot_q [2];
  logic [1:0] slot_we;

  // Handshake outputs depend on state only, never on in_valid/out_ready.
  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != 2'd0);

  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  always_comb begin
    wdata.result = in_result;
    wdata.rd     = in_ovf ? RSTATUS_REG : in_rd;
    wdata.ovf    = in_ovf;
  end

  for (genvar i = 0; i < 2; i++) begin : g_slot
    assign slot_we[i] = push && (wr_ptr_q == 1'(i));

    result_entry u_entry (
      .clock   (clock),
      .reset_n (reset_n),
      .we      (slot_we[i]),
      .d       (wdata),
      .q       (slot_q[i])
    );
  end

  // Outputs come straight from the head slot; no bypass from the inputs.
  assign head       = slot_q[rd_ptr_q];
  assign out_result = head.result;
  assign out_rd     = head.rd;
  assign out_ovf    = head.ovf;
  assign ovf_count  = ovf_count_q;

  always_comb begin
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ovf_count_d = ovf_count_q;

    if (flush) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end

    // The overflow counter survives flush; only accepted pushes count.
    if (push && in_ovf) begin
      ovf_count_d = sat_inc8(ovf_count_q);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q     <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      ovf_count_q <= 8'd0;
    end else begin
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ovf_count_q <= ovf_count_d;
    end
  end

endmodule
